// File: rtl/dm_cache_controller_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache controller.
// Combinational only; no latency or backpressure.
package dm_cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int sets, input int line_words);
    return addr_width - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU-side and memory-side signal bundle of the cache controller.
// slave = controller view, master = CPU/memory environment view.
interface dm_cache_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  iReq;
  logic                  iWriteEn;
  logic [3:0]            iByteEn;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [31:0]           iWriteData;
  logic [31:0]           oReadData;
  logic                  oReady;
  logic                  oMemReq;
  logic                  oMemWrite;
  logic [ADDR_WIDTH-1:0] oMemAddress;
  logic [31:0]           oMemWriteData;
  logic                  iMemAck;
  logic [31:0]           iMemReadData;

  modport slave (
    input  iReq, iWriteEn, iByteEn, iAddress, iWriteData, iMemAck, iMemReadData,
    output oReadData, oReady, oMemReq, oMemWrite, oMemAddress, oMemWriteData
  );

  modport master (
    output iReq, iWriteEn, iByteEn, iAddress, iWriteData, iMemAck, iMemReadData,
    input  oReadData, oReady, oMemReq, oMemWrite, oMemAddress, oMemWriteData
  );
endinterface

// File: rtl/dm_cache_controller_line_store.sv
// Valid/dirty/tag/data arrays: combinational read of one set, writes at the clock edge.
// Reset clears valid and dirty only; tag and data contents are don't-care until refilled.
module dm_cache_controller_line_store
  import dm_cache_controller_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int LINE_WORDS  = 4,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 26
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INDEX_BITS-1:0]             set_idx,
  output logic                              rd_valid,
  output logic                              rd_dirty,
  output logic [TAG_BITS-1:0]               rd_tag,
  output logic [LINE_WORDS-1:0][WORD_W-1:0] rd_line,
  input  logic                              word_we,
  input  logic [OFFSET_BITS-1:0]            word_idx,
  input  logic [BE_W-1:0]                   word_be,
  input  logic [WORD_W-1:0]                 word_dat,
  input  logic                              meta_we,
  input  logic                              meta_valid,
  input  logic                              meta_dirty,
  input  logic                              tag_we,
  input  logic [TAG_BITS-1:0]               tag_dat
);

  logic [SETS-1:0]                   valid_q, valid_d;
  logic [SETS-1:0]                   dirty_q, dirty_d;
  logic [TAG_BITS-1:0]               tag_q  [SETS];
  logic [TAG_BITS-1:0]               tag_d  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0] data_q [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0] data_d [SETS];

  assign rd_valid = valid_q[set_idx];
  assign rd_dirty = dirty_q[set_idx];
  assign rd_tag   = tag_q[set_idx];
  assign rd_line  = data_q[set_idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (meta_we) begin
      valid_d[set_idx] = meta_valid;
      dirty_d[set_idx] = meta_dirty;
    end
    if (tag_we) tag_d[set_idx] = tag_dat;
    if (word_we) begin
      data_d[set_idx][word_idx] = byte_merge(data_q[set_idx][word_idx], word_dat, word_be);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-back/write-allocate cache: hits complete in the request cycle,
// misses stall the CPU (oReady=0) through optional write-back plus word-by-word refill.
module dm_cache_controller
  import dm_cache_controller_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic                  iClk,
  input logic                  iRst,
  dm_cache_controller_if.slave bus
);

  localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
  localparam int INDEX_BITS  = index_bits(SETS);
  localparam int TAG_BITS    = tag_bits(ADDR_WIDTH, SETS, LINE_WORDS);
  localparam logic [OFFSET_BITS-1:0] CNT_LAST = OFFSET_BITS'(LINE_WORDS - 1);

  logic [OFFSET_BITS-1:0] req_word;
  logic [INDEX_BITS-1:0]  req_set;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   unused_byte_offset;

  assign req_word           = bus.iAddress[OFFSET_BITS+1:2];
  assign req_set            = bus.iAddress[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_tag            = bus.iAddress[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_byte_offset = ^bus.iAddress[1:0];

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]  miss_set_q, miss_set_d;
  logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;

  logic                              ls_valid, ls_dirty;
  logic [TAG_BITS-1:0]               ls_tag;
  logic [LINE_WORDS-1:0][WORD_W-1:0] ls_line;
  logic [INDEX_BITS-1:0]             ls_set;
  logic                              word_we, meta_we, meta_valid, meta_dirty, tag_we;
  logic [OFFSET_BITS-1:0]            word_idx;
  logic [BE_W-1:0]                   word_be;
  logic [WORD_W-1:0]                 word_dat;

  dm_cache_controller_line_store #(
    .SETS        (SETS),
    .LINE_WORDS  (LINE_WORDS),
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_line_store (
    .clk        (iClk),
    .rst        (iRst),
    .set_idx    (ls_set),
    .rd_valid   (ls_valid),
    .rd_dirty   (ls_dirty),
    .rd_tag     (ls_tag),
    .rd_line    (ls_line),
    .word_we    (word_we),
    .word_idx   (word_idx),
    .word_be    (word_be),
    .word_dat   (word_dat),
    .meta_we    (meta_we),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .tag_we     (tag_we),
    .tag_dat    (miss_tag_q)
  );

  // The missing set/tag are latched so the line completes even if the CPU drops iReq.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    miss_set_d        = miss_set_q;
    miss_tag_d        = miss_tag_q;
    ls_set            = req_set;
    word_we           = 1'b0;
    word_idx          = req_word;
    word_be           = bus.iByteEn;
    word_dat          = bus.iWriteData;
    meta_we           = 1'b0;
    meta_valid        = ls_valid;
    meta_dirty        = ls_dirty;
    tag_we            = 1'b0;
    bus.oReady        = 1'b0;
    bus.oReadData     = '0;
    bus.oMemReq       = 1'b0;
    bus.oMemWrite     = 1'b0;
    bus.oMemAddress   = '0;
    bus.oMemWriteData = '0;

    case (state_q)
      IDLE: begin
        if (bus.iReq) begin
          if (ls_valid && (ls_tag == req_tag)) begin
            bus.oReady    = 1'b1;
            bus.oReadData = ls_line[req_word];
            if (bus.iWriteEn) begin
              word_we    = 1'b1;
              meta_we    = 1'b1;
              meta_dirty = 1'b1;
            end
          end else begin
            meta_we    = 1'b1;
            meta_valid = 1'b0;
            cnt_d      = '0;
            miss_set_d = req_set;
            miss_tag_d = req_tag;
            state_d    = (ls_valid && ls_dirty) ? WRITEBACK : REFILL;
          end
        end
      end

      WRITEBACK: begin
        ls_set            = miss_set_q;
        bus.oMemReq       = 1'b1;
        bus.oMemWrite     = 1'b1;
        bus.oMemAddress   = {ls_tag, miss_set_q, cnt_q, 2'b00};
        bus.oMemWriteData = ls_line[cnt_q];
        if (bus.iMemAck) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            meta_we    = 1'b1;
            meta_dirty = 1'b0;
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        ls_set          = miss_set_q;
        bus.oMemReq     = 1'b1;
        bus.oMemAddress = {miss_tag_q, miss_set_q, cnt_q, 2'b00};
        if (bus.iMemAck) begin
          word_we  = 1'b1;
          word_idx = cnt_q;
          word_be  = '1;
          word_dat = bus.iMemReadData;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b0;
            tag_we     = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_set_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_set_q <= miss_set_d;
      miss_tag_q <= miss_tag_d;
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Bench for dm_cache_controller: directed scenarios plus a randomized run against a line-level model.
module tb_dm_cache_controller;

  localparam int SETS = 16;
  localparam int LW   = 4;
  localparam int AW   = 32;

  logic iClk = 1'b0;
  logic iRst;

  dm_cache_controller_if #(.ADDR_WIDTH(AW)) bus();

  dm_cache_controller #(.SETS(SETS), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] dat;
  } txn_t;

  txn_t        txn_q[$];
  logic [31:0] phys_mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          wcnt = 0;
  logic        armed = 1'b0;
  logic [31:0] armed_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: acks on the 2nd cycle a request is seen, one-cycle pulse; watches address stability.
  always @(negedge iClk) begin
    if (armed && bus.oMemReq && !iRst) begin
      checks++;
      if (bus.oMemAddress !== armed_addr) begin
        errors++;
        $display("FAIL mem_addr_stable: got %h want %h", bus.oMemAddress, armed_addr);
      end
    end
    if (iRst) begin
      bus.iMemAck = 1'b0;
      wcnt = 0;
    end else begin
      if (bus.iMemAck) begin
        bus.iMemAck = 1'b0;
        wcnt = 0;
      end
      if (!bus.oMemReq) begin
        wcnt = 0;
      end else if (wcnt == 1) begin
        bus.iMemAck = 1'b1;
        if (bus.oMemWrite) begin
          phys_mem[bus.oMemAddress] = bus.oMemWriteData;
          txn_q.push_back('{1'b1, bus.oMemAddress, bus.oMemWriteData});
        end else begin
          bus.iMemReadData = mem_rd(bus.oMemAddress);
          txn_q.push_back('{1'b0, bus.oMemAddress, bus.iMemReadData});
        end
      end else begin
        wcnt++;
      end
    end
    armed      = bus.oMemReq && !bus.iMemAck && !iRst;
    armed_addr = bus.oMemAddress;
  end

  // Called at posedge+1; returns at posedge+1 after the completing edge, iReq left asserted.
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                        output logic mreq_seen, output logic timeout);
    txn_q.delete();
    bus.iReq = 1'b1; bus.iWriteEn = we; bus.iByteEn = be;
    bus.iAddress = addr; bus.iWriteData = wd;
    rd = '0; cyc = 0; mreq_seen = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge iClk);
      if (bus.oMemReq) mreq_seen = 1'b1;
      if (bus.oReady) begin
        rd = bus.oReadData;
        timeout = 1'b0;
        break;
      end
      cyc++;
    end
    @(posedge iClk); #1;
  endtask

  task automatic idle();
    bus.iReq = 1'b0; bus.iWriteEn = 1'b0; bus.iByteEn = '0;
    bus.iAddress = '0; bus.iWriteData = '0;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    idle();
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.oReady); end
    checks++; if (bus.oMemReq !== 1'b0) begin errors++; $display("FAIL rst_memreq: got %b want 0", bus.oMemReq); end
    checks++; if (bus.oMemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite: got %b want 0", bus.oMemWrite); end
    checks++; if (bus.oMemAddress !== 32'h0) begin errors++; $display("FAIL rst_memaddr: got %h want 0", bus.oMemAddress); end
    checks++; if (bus.oMemWriteData !== 32'h0) begin errors++; $display("FAIL rst_memwdata: got %h want 0", bus.oMemWriteData); end
    checks++; if (bus.oReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.oReadData); end
    @(posedge iClk); #1;
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int cyc; logic ms, to;
    access(1'b0, 4'h0, 32'h0000_0104, 32'h0, rd, cyc, ms, to);
    checks++; if (to) begin errors++; $display("FAIL cold_timeout: got timeout want ready"); end
    checks++; if (cyc != 9) begin errors++; $display("FAIL cold_latency: got %0d want 9", cyc); end
    checks++;
    if (txn_q.size() != 4) begin
      errors++; $display("FAIL cold_txn_count: got %0d want 4", txn_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (txn_q[i].wr !== 1'b0 || txn_q[i].addr !== 32'h100 + 4*i) begin
          errors++; $display("FAIL cold_txn%0d: got wr=%b addr=%h want wr=0 addr=%h", i, txn_q[i].wr, txn_q[i].addr, 32'h100 + 4*i);
        end
      end
    end
    checks++; if (rd !== 32'hA5A5_0104) begin errors++; $display("FAIL cold_rdata: got %h want A5A50104", rd); end
  endtask

  task automatic test_hit_load();
    logic [31:0] rd; int cyc; logic ms, to;
    access(1'b0, 4'h0, 32'h0000_0108, 32'h0, rd, cyc, ms, to);
    checks++; if (to || cyc != 0) begin errors++; $display("FAIL hit_latency: got %0d want 0", cyc); end
    checks++; if (rd !== 32'hA5A5_0108) begin errors++; $display("FAIL hit_rdata: got %h want A5A50108", rd); end
    checks++; if (ms !== 1'b0 || txn_q.size() != 0) begin errors++; $display("FAIL hit_memreq: got req=%b txns=%0d want 0/0", ms, txn_q.size()); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int cyc; logic ms, to;
    access(1'b1, 4'b0011, 32'h0000_0104, 32'hDEAD_BEEF, rd, cyc, ms, to);
    checks++; if (to || cyc != 0) begin errors++; $display("FAIL store_latency: got %0d want 0", cyc); end
    checks++; if (ms !== 1'b0 || txn_q.size() != 0) begin errors++; $display("FAIL store_traffic: got req=%b txns=%0d want 0/0", ms, txn_q.size()); end
    access(1'b0, 4'h0, 32'h0000_0104, 32'h0, rd, cyc, ms, to);
    checks++; if (to || cyc != 0) begin errors++; $display("FAIL store_readback_latency: got %0d want 0", cyc); end
    checks++; if (rd !== 32'hA5A5_BEEF) begin errors++; $display("FAIL store_merge: got %h want A5A5BEEF", rd); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd; int cyc; logic ms, to; logic [31:0] ew;
    access(1'b0, 4'h0, 32'h0000_0204, 32'h0, rd, cyc, ms, to);
    checks++; if (to || cyc != 17) begin errors++; $display("FAIL evict_latency: got %0d want 17", cyc); end
    checks++;
    if (txn_q.size() != 8) begin
      errors++; $display("FAIL evict_txn_count: got %0d want 8", txn_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ew = (i == 1) ? 32'hA5A5_BEEF : ((32'h100 + 4*i) ^ 32'hA5A5_0000);
        checks++;
        if (txn_q[i].wr !== 1'b1 || txn_q[i].addr !== 32'h100 + 4*i || txn_q[i].dat !== ew) begin
          errors++; $display("FAIL evict_wb%0d: got wr=%b addr=%h dat=%h want wr=1 addr=%h dat=%h", i, txn_q[i].wr, txn_q[i].addr, txn_q[i].dat, 32'h100 + 4*i, ew);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (txn_q[4+i].wr !== 1'b0 || txn_q[4+i].addr !== 32'h200 + 4*i) begin
          errors++; $display("FAIL evict_rf%0d: got wr=%b addr=%h want wr=0 addr=%h", i, txn_q[4+i].wr, txn_q[4+i].addr, 32'h200 + 4*i);
        end
      end
    end
    checks++; if (rd !== 32'hA5A5_0204) begin errors++; $display("FAIL evict_rdata: got %h want A5A50204", rd); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; int cyc; logic ms, to; logic found;
    access(1'b1, 4'hF, 32'h0000_0128, 32'h1234_5678, rd, cyc, ms, to);
    idle();
    @(posedge iClk); #1;
    txn_q.delete();
    bus.iReq = 1'b1; bus.iAddress = 32'h0000_0300;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge iClk); #1;
      if (txn_q.size() == 1 && bus.oMemReq && !bus.iMemAck) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: got no 2nd refill wait want one"); end
    iRst = 1'b1;
    idle();
    @(posedge iClk); #1 iRst = 1'b0;
    @(negedge iClk);
    checks++; if (bus.oMemReq !== 1'b0) begin errors++; $display("FAIL rstmid_memreq: got %b want 0", bus.oMemReq); end
    checks++; if (bus.oMemAddress !== 32'h0) begin errors++; $display("FAIL rstmid_memaddr: got %h want 0", bus.oMemAddress); end
    @(posedge iClk); #1;
    access(1'b0, 4'h0, 32'h0000_0128, 32'h0, rd, cyc, ms, to);
    checks++; if (to || cyc != 9 || txn_q.size() != 4) begin errors++; $display("FAIL rstmid_cold_dirty: got cyc=%0d txns=%0d want 9/4", cyc, txn_q.size()); end
    checks++; if (rd !== 32'hA5A5_0128) begin errors++; $display("FAIL rstmid_lost_store: got %h want A5A50128", rd); end
    access(1'b0, 4'h0, 32'h0000_0300, 32'h0, rd, cyc, ms, to);
    checks++;
    if (to || cyc != 9 || txn_q.size() != 4) begin
      errors++; $display("FAIL rstmid_reissue: got cyc=%0d txns=%0d want 9/4", cyc, txn_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (txn_q[i].wr !== 1'b0 || txn_q[i].addr !== 32'h300 + 4*i) begin
          errors++; $display("FAIL rstmid_rf%0d: got addr=%h want %h", i, txn_q[i].addr, 32'h300 + 4*i);
        end
      end
    end
    checks++; if (rd !== 32'hA5A5_0300) begin errors++; $display("FAIL rstmid_rdata: got %h want A5A50300", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, a; int cyc; logic ms, to; int ready_cnt;
    ready_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 4'h0, 32'h300 + 4*i, 32'h0, rd, cyc, ms, to);
      if (!to && cyc == 0 && rd === ((32'h300 + 4*i) ^ 32'hA5A5_0000)) ready_cnt++;
    end
    checks++; if (ready_cnt != 4) begin errors++; $display("FAIL b2b_hits: got %0d want 4", ready_cnt); end
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_1100;
      access(1'b0, 4'h0, a, 32'h0, rd, cyc, ms, to);
      checks++;
      if (to || cyc != 9 || txn_q.size() != 4 || txn_q[0].addr !== a) begin
        errors++; $display("FAIL alt_miss%0d: got cyc=%0d txns=%0d want 9/4 at %h", i, cyc, txn_q.size(), a);
      end
      checks++; if (rd !== (a ^ 32'hA5A5_0000)) begin errors++; $display("FAIL alt_rdata%0d: got %h want %h", i, rd, a ^ 32'hA5A5_0000); end
    end
  endtask

  // Reference: per-set valid/dirty/tag/line copy plus an expected backing memory.
  logic        m_valid [SETS];
  logic        m_dirty [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_line  [SETS][LW];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd, la; int cyc, exp_cyc, st, tg, w; logic ms, to, we, hit;
    logic [3:0] be;
    txn_t exp_q[$];
    idle();
    iRst = 1'b1;
    @(posedge iClk); #1 iRst = 1'b0;
    for (int s = 0; s < SETS; s++) begin m_valid[s] = 1'b0; m_dirty[s] = 1'b0; end
    for (int n = 0; n < 150; n++) begin
      tg = 32'h40 + $urandom_range(0, 3); st = $urandom_range(0, 3); w = $urandom_range(0, 3);
      addr = (tg << 8) | (st << 4) | (w << 2);
      we = 1'($urandom_range(0, 1)); be = 4'($urandom); wd = $urandom;
      exp_q.delete();
      hit = m_valid[st] && (m_tag[st] == tg);
      if (!hit) begin
        if (m_valid[st] && m_dirty[st]) begin
          for (int j = 0; j < LW; j++) begin
            la = (m_tag[st] << 8) | (st << 4) | (j << 2);
            exp_q.push_back('{1'b1, la, m_line[st][j]});
            ref_mem[la] = m_line[st][j];
          end
        end
        for (int j = 0; j < LW; j++) begin
          la = (tg << 8) | (st << 4) | (j << 2);
          exp_q.push_back('{1'b0, la, 32'h0});
          m_line[st][j] = ref_rd(la);
        end
        m_valid[st] = 1'b1; m_dirty[st] = 1'b0; m_tag[st] = tg;
      end
      exp_rd = m_line[st][w];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_line[st][w][8*b +: 8] = wd[8*b +: 8];
        m_dirty[st] = 1'b1;
      end
      exp_cyc = hit ? 0 : 1 + 2 * exp_q.size();
      access(we, be, addr, wd, rd, cyc, ms, to);
      checks++; if (to || cyc != exp_cyc) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d addr %h", n, cyc, exp_cyc, addr); end
      checks++;
      if (txn_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_txn_count: got %0d want %0d", n, txn_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          checks++;
          if (txn_q[j].wr !== exp_q[j].wr || txn_q[j].addr !== exp_q[j].addr ||
              (exp_q[j].wr && txn_q[j].dat !== exp_q[j].dat)) begin
            errors++; $display("FAIL rnd%0d_txn%0d: got wr=%b addr=%h dat=%h want wr=%b addr=%h dat=%h", n, j,
                               txn_q[j].wr, txn_q[j].addr, txn_q[j].dat, exp_q[j].wr, exp_q[j].addr, exp_q[j].dat);
          end
        end
      end
      if (!we) begin
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h addr %h", n, rd, exp_rd, addr); end
      end
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_load();
    test_hit_load();
    test_store_hit();
    test_dirty_evict();
    test_reset_mid_refill();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
